// File: rtl/matmul_pkg.sv
// Shared constants and FSM state type for the 4x4 matmul/pooling engine and its loader.
//   ADDR_W / DATA_W : RAM address and word widths
//   A_BASE          : A matrix, row-major, 4 words
//   B_BASE          : B matrix, column-major, 4 words
//   C_BASE          : pooled result word {P11,P10,P01,P00}
package matmul_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] A_BASE = 10'h000;
    localparam logic [ADDR_W-1:0] B_BASE = 10'h100;
    localparam logic [ADDR_W-1:0] C_BASE = 10'h200;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StKick,
        StWaitBusy,
        StWaitDone,
        StSettle,
        StReadC,
        StCapture,
        StOut,
        StError
    } state_e;

endpackage

// File: rtl/matmul_loader_byte_packer.sv
// Assembles four bytes into one 32-bit word, first byte in the LSB lane.
//   clk, rstn      : clock, asynchronous active-low reset
//   byte_valid_i   : a byte is being accepted this cycle
//   lane_i         : byte position within the word (0 = bits 7:0)
//   byte_i         : byte value
//   word_valid_o   : one-cycle pulse, the cycle after lane 3 is accepted
//   word_o         : completed word while word_valid_o is high, zero otherwise
module matmul_loader_byte_packer
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              byte_valid_i,
    input  logic [1:0]        lane_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);

    logic [23:0]       partial_q;
    logic              word_valid_q;
    logic [DATA_W-1:0] word_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            partial_q    <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            // Word output is zero outside the pulse so it can feed the shared RAM OR-mux directly.
            word_valid_q <= 1'b0;
            word_q       <= '0;
            if (byte_valid_i) begin
                unique case (lane_i)
                    2'd0: partial_q[7:0]   <= byte_i;
                    2'd1: partial_q[15:8]  <= byte_i;
                    2'd2: partial_q[23:16] <= byte_i;
                    2'd3: begin
                        word_valid_q <= 1'b1;
                        word_q       <= {byte_i, partial_q};
                    end
                endcase
            end
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/matmul_loader.sv
// Feeder/sequencer for the 4x4 matmul/pooling engine. Takes a 32-byte job over a byte stream,
// writes A rows to A_BASE..+3 and B columns to B_BASE..+3, kicks the engine, waits for it to
// finish, reads the pooled word at C_BASE and offers it on a valid/ready result port.
// All mem_* outputs are zero when idle so they can be OR-muxed with the engine's RAM port.
//   clk, rstn                          : clock, asynchronous active-low reset
//   s_valid, s_ready, s_data           : input byte stream
//   mem_write_en, mem_read_en          : RAM strobes
//   mem_addr, mem_wdata, mem_rdata     : RAM address / write data / read data (1-cycle latency)
//   mm_kick_start, mm_ready            : engine start pulse / engine idle flag
//   m_valid, m_ready, m_data           : result port
//   busy                               : first byte accepted until result accepted
//   err                                : watchdog expired
// Optional: define MATMUL_LOADER_TIMEOUT_EN to enable a watchdog on the engine wait (ERROR state).
module matmul_loader
    import matmul_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mm_kick_start,
    input  logic              mm_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              err
);

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYC - 1);

    state_e            state_q;
    logic [4:0]        cnt_q;
    logic [7:0]        settle_q;
    logic              s_ready_q;
    logic              busy_q;
    logic              kick_q;
    logic              read_en_q;
    logic              m_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] m_data_q;

    logic              s_xfer;
    logic              pk_valid;
    logic [DATA_W-1:0] pk_word;

    assign s_xfer = s_valid & s_ready_q;

`ifdef MATMUL_LOADER_TIMEOUT_EN
    localparam logic [15:0] WdLast = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wd_q;
    logic        err_q;
`endif

    matmul_loader_byte_packer u_packer (
        .clk          (clk),
        .rstn         (rstn),
        .byte_valid_i (s_xfer),
        .lane_i       (cnt_q[1:0]),
        .byte_i       (s_data),
        .word_valid_o (pk_valid),
        .word_o       (pk_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            settle_q  <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            kick_q    <= 1'b0;
            read_en_q <= 1'b0;
            m_valid_q <= 1'b0;
            addr_q    <= '0;
            m_data_q  <= '0;
`ifdef MATMUL_LOADER_TIMEOUT_EN
            wd_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            kick_q    <= 1'b0;
            read_en_q <= 1'b0;
            addr_q    <= '0;
            case (state_q)
                StIdle, StLoad: begin
                    s_ready_q <= 1'b1;
                    if (s_xfer) begin
                        cnt_q   <= cnt_q + 5'd1;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                        // Address lines up with the packer's word pulse on the next cycle.
                        if (cnt_q[1:0] == 2'd3) begin
                            addr_q <= (cnt_q[4] ? B_BASE : A_BASE)
                                      + {{(ADDR_W-2){1'b0}}, cnt_q[3:2]};
                        end
                        if (cnt_q == 5'd31) begin
                            state_q   <= StKick;
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                StKick: begin
                    if (mm_ready) begin
                        kick_q  <= 1'b1;
                        state_q <= StWaitBusy;
`ifdef MATMUL_LOADER_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                    end
                end
                StWaitBusy: begin
                    if (!mm_ready) state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (mm_ready) begin
                        state_q  <= StSettle;
                        settle_q <= '0;
                    end
                end
                StSettle: begin
                    if (settle_q == SettleLast) begin
                        state_q   <= StReadC;
                        read_en_q <= 1'b1;
                        addr_q    <= C_BASE;
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                StReadC: state_q <= StCapture;
                StCapture: begin
                    m_data_q  <= mem_rdata;
                    m_valid_q <= 1'b1;
                    state_q   <= StOut;
                end
                StOut: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        m_data_q  <= '0;
                        busy_q    <= 1'b0;
                        cnt_q     <= '0;
                        s_ready_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
`ifdef MATMUL_LOADER_TIMEOUT_EN
                StError: begin
                    // Terminal until reset.
                    s_ready_q <= 1'b0;
                    m_valid_q <= 1'b0;
                    busy_q    <= 1'b1;
                end
`endif
                default: state_q <= StIdle;
            endcase
`ifdef MATMUL_LOADER_TIMEOUT_EN
            // Overrides the normal wait transitions when the limit is hit.
            if (state_q == StWaitBusy || state_q == StWaitDone) begin
                if (wd_q == WdLast) begin
                    state_q <= StError;
                    err_q   <= 1'b1;
                end else begin
                    wd_q <= wd_q + 16'd1;
                end
            end
`endif
        end
    end

    assign s_ready       = s_ready_q;
    assign mem_write_en  = pk_valid;
    assign mem_wdata     = pk_word;
    assign mem_read_en   = read_en_q;
    assign mem_addr      = addr_q;
    assign mm_kick_start = kick_q;
    assign m_valid       = m_valid_q;
    assign m_data        = m_data_q;
    assign busy          = busy_q;

`ifdef MATMUL_LOADER_TIMEOUT_EN
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_loader.sv
// Randomized bench for matmul_loader with a RAM + engine model and a per-cycle compare process.
module tb_matmul_loader;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rstn;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mm_kick_start;
    logic        mm_ready;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        busy;
    logic        err;

    matmul_loader #(
        .SETTLE_CYC  (2),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .mem_write_en  (mem_write_en),
        .mem_read_en   (mem_read_en),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mm_kick_start (mm_kick_start),
        .mm_ready      (mm_ready),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .busy          (busy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the whole job ----------------
    // A[i][k] = byte 4i+k, B[k][j] = byte 16+4j+k; C = A*B mod 256; 2x2 max pooling.
    function automatic logic [31:0] pool_result(input logic [255:0] job);
        logic [7:0] c [4][4];
        logic [7:0] p [4];
        logic [7:0] m;
        int s;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    s += int'(job[8*(4*i+k) +: 8]) * int'(job[8*(16+4*j+k) +: 8]);
                end
                c[i][j] = 8'(s);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int q = 0; q < 2; q++) begin
                m = c[2*r][2*q];
                if (c[2*r][2*q+1] > m) m = c[2*r][2*q+1];
                if (c[2*r+1][2*q] > m) m = c[2*r+1][2*q];
                if (c[2*r+1][2*q+1] > m) m = c[2*r+1][2*q+1];
                p[2*r+q] = m;
            end
        end
        return {p[3], p[2], p[1], p[0]};
    endfunction

    wr_t         exp_wr [$];
    wr_t         wr_log [$];
    logic [31:0] exp_res [$];
    logic [255:0] cur_job;
    int          job_idx = 0;
    bit          job_active = 0;
    bit          phase_busy = 0;
    bit          expect_err = 0;
    int          kicks_seen = 0;
    int          reads_seen = 0;
    int          xfers = 0;
    logic [31:0] last_md;

    // ---------------- RAM + engine model ----------------
    logic [31:0] ram [0:1023];
    bit          eng_ready;
    int          eng_st;
    int          eng_cnt;
    int          eng_len = 3;
    bit          eng_stuck = 0;
    bit          hold_ready = 0;

    assign mm_ready = eng_ready & ~hold_ready;

    always @(posedge clk) begin
        logic [255:0] v;
        if (mem_write_en) ram[mem_addr] <= mem_wdata;
        mem_rdata <= mem_read_en ? ram[mem_addr] : 32'h0;
        if (!rstn) begin
            eng_ready <= 1'b1;
            eng_st    <= 0;
        end else begin
            case (eng_st)
                0: if (mm_kick_start) eng_st <= 1;
                1: begin
                    eng_ready <= 1'b0;
                    eng_cnt   <= eng_len;
                    eng_st    <= 2;
                end
                default: begin
                    if (!eng_stuck) begin
                        if (eng_cnt == 0) begin
                            for (int k = 0; k < 4; k++) begin
                                v[32*k +: 32]     = ram[k];
                                v[128+32*k +: 32] = ram[256+k];
                            end
                            ram[10'h200] <= pool_result(v);
                            eng_ready    <= 1'b1;
                            eng_st       <= 0;
                        end else begin
                            eng_cnt <= eng_cnt - 1;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    bit          prev_kick, prev_mmr, prev_mv, prev_mr;
    logic [31:0] prev_md;

    always @(negedge clk) begin
        wr_t e;
        logic [31:0] r;
        if (!rstn) begin
            prev_kick = 0; prev_mmr = 0; prev_mv = 0; prev_mr = 0; prev_md = '0;
        end else begin
            if (mem_write_en) begin
                chk("write_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                    e.addr = mem_addr;
                    e.data = mem_wdata;
                    wr_log.push_back(e);
                end
            end else begin
                chk("wdata_idle_zero", mem_wdata, 0);
                if (!mem_read_en) chk("addr_idle_zero", mem_addr, 0);
            end
            if (mem_read_en) begin
                reads_seen++;
                chk("rd_addr", mem_addr, 10'h200);
                chk("rd_wr_exclusive", mem_write_en, 0);
            end
            if (mm_kick_start) begin
                kicks_seen++;
                chk("kick_needs_ready", prev_mmr, 1);
                chk("kick_one_cycle", prev_kick, 0);
            end
            if (prev_mv && !prev_mr) begin
                chk("m_valid_hold", m_valid, 1);
                chk("m_data_hold", m_data, prev_md);
            end
            chk("busy", busy, job_active);
            if (phase_busy) chk("s_ready_low_busy", s_ready, 0);
            if (!expect_err) chk("err_low", err, 0);
            if (m_valid && m_ready) begin
                xfers++;
                last_md = m_data;
                chk("result_expected", exp_res.size() > 0, 1);
                if (exp_res.size() > 0) begin
                    r = exp_res.pop_front();
                    chk("m_data", m_data, r);
                end
                job_active = 0;
                phase_busy = 0;
            end
            prev_kick = mm_kick_start;
            prev_mmr  = mm_ready;
            prev_mv   = m_valid;
            prev_mr   = m_ready;
            prev_md   = m_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic flush_model();
        exp_wr.delete();
        exp_res.delete();
        job_idx    = 0;
        job_active = 0;
        phase_busy = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int   n;
        int   w;
        wr_t  e;
        if (gaps && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 4)) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        if (job_idx != 0) chk("s_ready_mid_job", s_ready, 1);
        n = 0;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            chk("s_ready_timeout", s_ready, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        job_active = 1;
        cur_job[8*job_idx +: 8] = b;
        if (job_idx % 4 == 3) begin
            w      = job_idx / 4;
            e.addr = ((w < 4) ? 10'h000 : 10'h100) + 10'(w % 4);
            e.data = cur_job[32*w +: 32];
            exp_wr.push_back(e);
        end
        job_idx++;
        if (job_idx == 32) begin
            job_idx    = 0;
            phase_busy = 1;
            exp_res.push_back(pool_result(cur_job));
        end
    endtask

    task automatic run_job(input logic [255:0] job, input bit gaps, input int hold,
                           input int kick_hold);
        int n;
        int k0, r0, x0;
        k0 = kicks_seen; r0 = reads_seen; x0 = xfers;
        wr_log.delete();
        eng_len = $urandom_range(0, 20);
        if (kick_hold > 0) hold_ready = 1;
        for (int k = 0; k < 32; k++) send_byte(job[8*k +: 8], gaps);
        // Offer bytes while busy; they must not be consumed.
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        if (kick_hold > 0) begin
            repeat (kick_hold) begin
                @(posedge clk); #1;
            end
            chk("no_kick_while_not_ready", kicks_seen, k0);
            hold_ready = 0;
        end
        n = 0;
        while (!m_valid && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("m_valid_seen", m_valid, 1);
        s_valid = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
        end
        if (hold > 0) chk("m_valid_after_hold", m_valid, 1);
        m_ready = 1'b1;
        n = 0;
        while (xfers == x0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        m_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("single_transfer", xfers, x0 + 1);
        chk("m_valid_dropped", m_valid, 0);
        chk("busy_dropped", busy, 0);
        chk("one_kick", kicks_seen, k0 + 1);
        chk("one_read", reads_seen, r0 + 1);
        chk("eight_writes", wr_log.size(), 8);
        chk("writes_drained", exp_wr.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_mem_we"}, mem_write_en, 0);
        chk({tag, "_mem_re"}, mem_read_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_kick"}, mm_kick_start, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    logic [255:0] job;

    initial begin
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1: all-ones job
        for (int k = 0; k < 32; k++) job[8*k +: 8] = 8'h01;
        run_job(job, 0, 0, 0);
        chk("t1_result", last_md, 32'h04040404);
        if (wr_log.size() == 8) begin
            chk("t1_first_wr", wr_log[0].data, 32'h01010101);
            chk("t1_b_addr", wr_log[4].addr, 10'h100);
        end

        // 2: counting bytes with gaps
        for (int k = 0; k < 32; k++) job[8*k +: 8] = 8'(k);
        run_job(job, 1, 1, 0);
        if (wr_log.size() == 8) begin
            chk("t2_first_addr", wr_log[0].addr, 10'h000);
            chk("t2_first_data", wr_log[0].data, 32'h03020100);
            chk("t2_last_addr", wr_log[7].addr, 10'h103);
            chk("t2_last_data", wr_log[7].data, 32'h1F1E1D1C);
        end

        // 3: result held back for 10 cycles
        for (int k = 0; k < 32; k++) job[8*k +: 8] = 8'($urandom);
        run_job(job, 1, 10, 0);

        // 4: reset after 10 bytes
        for (int k = 0; k < 10; k++) send_byte(8'($urandom), 1);
        rstn = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 32; k++) job[8*k +: 8] = 8'($urandom);
        run_job(job, 1, 0, 0);
        if (wr_log.size() == 8) chk("t4_restart_addr", wr_log[0].addr, 10'h000);

        // 5: engine not ready when KICK is entered
        for (int k = 0; k < 32; k++) job[8*k +: 8] = 8'($urandom);
        run_job(job, 0, 2, 15);

        // random jobs
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 32; k++) job[8*k +: 8] = 8'($urandom);
            run_job(job, 1, $urandom_range(0, 4), $urandom_range(0, 1) * 5);
        end

`ifdef MATMUL_LOADER_TIMEOUT_EN
        // 6: engine stuck busy, watchdog
        begin
            int n;
            expect_err = 1;
            eng_stuck  = 1;
            for (int k = 0; k < 32; k++) send_byte(8'($urandom), 0);
            n = 0;
            while (!mm_kick_start && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            chk("t6_kick", mm_kick_start, 1);
            for (int c = 1; c <= 64; c++) begin
                @(posedge clk); #1;
                if (c == 63) chk("t6_err_early", err, 0);
            end
            chk("t6_err_at_limit", err, 1);
            repeat (10) @(posedge clk);
            #1;
            chk("t6_err_held", err, 1);
            chk("t6_s_ready", s_ready, 0);
            chk("t6_m_valid", m_valid, 0);
            chk("t6_busy", busy, 1);
            rstn = 1'b0;
            #1;
            chk("t6_err_reset", err, 0);
            flush_model();
            eng_stuck  = 0;
            expect_err = 0;
            repeat (2) @(posedge clk);
            #1;
            rstn = 1'b1;
            @(posedge clk); #1;
        end
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
